// File: rtl/pdm_mic_frontend.sv
// PDM microphone front-end: bit-clock divider, 2-flop capture, boxcar decimation
// to signed 16-bit PCM, and a first-word-fall-through sample FIFO with sticky overflow.
module pdm_mic_frontend #(
  parameter int CLK_DIV  = 25,
  parameter int DEC_RATE = 128,
  parameter int FIFO_AW  = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic        mic_clk,
  input  logic        mic_data,
  output logic        mic_LRsel,
  input  logic        rd,
  output logic [15:0] dout,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  input  logic        clr_ovf
);
  localparam int DW    = $clog2(CLK_DIV);
  localparam int BW    = $clog2(DEC_RATE);
  localparam int OW    = $clog2(DEC_RATE + 1);
  localparam int SHIFT = 15 - BW;
  localparam int CW    = FIFO_AW + 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [DW-1:0]      DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0]      BIT_LAST = BW'(DEC_RATE - 1);
  localparam logic signed [31:0] DEC_S    = 32'(DEC_RATE);

  logic [DW-1:0]      r_div;
  logic               r_mic_clk;
  logic               r_sync1;
  logic               r_sync2;
  logic [OW-1:0]      r_ones;
  logic [BW-1:0]      r_bitcnt;
  logic [15:0]        r_pcm;
  logic               r_pcm_vld;
  logic [15:0]        r_mem [0:DEPTH-1];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_empty;
  logic               r_full;
  logic               r_ovf;
  logic [15:0]        r_dout;

  logic               w_tick;
  logic               w_sample;
  logic               w_last_bit;
  logic [OW-1:0]      w_ones_tot;
  logic signed [31:0] w_v;
  logic signed [31:0] w_v_sat;
  logic [15:0]        w_pcm;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_wr;
  logic [CW-1:0]      w_count_nxt;

  // Sampling happens on the divider wrap that drives mic_clk low (end of high phase).
  assign w_tick     = en && (r_div == DIV_LAST);
  assign w_sample   = w_tick && r_mic_clk;
  assign w_last_bit = (r_bitcnt == BIT_LAST);
  assign w_ones_tot = r_ones + OW'(r_sync2);

  // v = 2*ones - DEC_RATE, with the lone positive overrange code clipped.
  assign w_v     = $signed(32'({w_ones_tot, 1'b0})) - DEC_S;
  assign w_v_sat = (w_v == DEC_S) ? (DEC_S - 32'sd1) : w_v;
  assign w_pcm   = 16'(w_v_sat <<< SHIFT);

  assign w_push      = r_pcm_vld;
  assign w_pop       = rd && !r_empty;
  assign w_drop      = w_push && r_full && !rd;
  assign w_wr        = w_push && !w_drop;
  assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);

  // Two-flop synchronizer for the asynchronous PDM input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= mic_data;
      r_sync2 <= r_sync1;
    end
  end

  // Bit-clock divider, ones accumulator and PCM sample formation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div     <= '0;
      r_mic_clk <= 1'b0;
      r_ones    <= '0;
      r_bitcnt  <= '0;
      r_pcm     <= 16'h0000;
      r_pcm_vld <= 1'b0;
    end else begin
      r_pcm_vld <= 1'b0;
      if (!en) begin
        r_div     <= '0;
        r_mic_clk <= 1'b0;
        r_ones    <= '0;
        r_bitcnt  <= '0;
      end else begin
        if (w_tick) begin
          r_div     <= '0;
          r_mic_clk <= ~r_mic_clk;
        end else begin
          r_div <= r_div + DW'(1);
        end
        if (w_sample) begin
          if (w_last_bit) begin
            r_ones    <= '0;
            r_bitcnt  <= '0;
            r_pcm     <= w_pcm;
            r_pcm_vld <= 1'b1;
          end else begin
            r_ones   <= w_ones_tot;
            r_bitcnt <= r_bitcnt + BW'(1);
          end
        end
      end
    end
  end

  // Sample storage; stale contents are harmless because the pointers gate them.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= r_pcm;
    end
  end

  // FIFO pointers, registered flags and the fall-through head register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_dout   <= 16'h0000;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == CW'(DEPTH));
      if (w_pop) begin
        r_dout <= ((r_count == CW'(1)) && w_wr) ? r_pcm : r_mem[r_rd_ptr + FIFO_AW'(1)];
      end else if (w_wr && r_empty) begin
        r_dout <= r_pcm;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign mic_clk   = r_mic_clk;
  assign mic_LRsel = 1'b0;
  assign dout      = r_dout;
  assign empty     = r_empty;
  assign full      = r_full;
  assign overflow  = r_ovf;

endmodule

// File: doc/pdm_mic_frontend.md
# pdm_mic_frontend

Front-end for a PDM MEMS microphone that feeds the microphone MMIO user core.
- Generates the microphone bit clock and captures the 1-bit PDM stream.
- Decimates the stream with a boxcar (ones-count) filter into signed 16-bit PCM samples.
- Buffers samples in a first-word-fall-through FIFO; the slot core reads it over a pop handshake and reports a sticky overflow flag to software.

## Interface
Parameters:
- CLK_DIV, 25: half-period of mic_clk in clk cycles (100 MHz → 2 MHz); legal range ≥ 4.
- DEC_RATE, 128: PDM bits per PCM sample; power of two, 4..32768.
- FIFO_AW, 5: FIFO address width; depth is 2^FIFO_AW.

Ports:
- clk, in, 1: system clock; one clock domain only.
- reset, in, 1: synchronous, active-high reset.
- en, in, 1: capture enable.
- mic_clk, out, 1: PDM bit clock to the microphone.
- mic_data, in, 1: PDM data from the microphone; asynchronous.
- mic_LRsel, out, 1: channel select; tied to 0 (data valid on mic_clk rising edge).
- rd, in, 1: pop request.
- dout, out, 16: FIFO head sample, signed.
- empty, out, 1: FIFO empty.
- full, out, 1: FIFO full.
- overflow, out, 1: sticky flag; a sample was dropped.
- clr_ovf, in, 1: clears overflow.

## Operation
- **Reset values:** mic_clk=0, mic_LRsel=0, dout=0, empty=1, full=0, overflow=0. Divider, bit counter and accumulator are 0. FIFO pointers are 0.
- **Divider**
  - While en=1, the counter runs 0..CLK_DIV-1 and toggles mic_clk at CLK_DIV-1, then returns to 0.
  - While en=0, the counter, mic_clk, bit counter and accumulator are held at 0.
  - FIFO contents and the rd path are unaffected by en.
- **Capture**
  - mic_data passes through a 2-flop synchronizer.
  - The synchronized bit is sampled in the cycle where mic_clk toggles 1→0, i.e. at the end of the high phase.
- **Accumulate**
  - ones (width $clog2(DEC_RATE+1)) increments on each sampled 1.
  - bitcnt counts samples 0..DEC_RATE-1.
- **Sample formation** (on the DEC_RATE-th sample, that bit included):
  - v = 2·ones − DEC_RATE, signed; range −DEC_RATE..+DEC_RATE.
  - Saturate +DEC_RATE to DEC_RATE−1.
  - pcm = v << (15 − log2(DEC_RATE)), 16 bits.
  - Then ones and bitcnt clear, so the next window starts fresh with no gap.
- **Push:** the pcm is written to the FIFO one cycle after formation.
  - If full=1 and rd=0 in the push cycle, the sample is dropped and overflow is set to 1.
  - If full=1 and rd=1 in the same cycle, the pop and the push both occur; no overflow.
- **Pop:** rd with empty=0 advances the read pointer. rd with empty=1 is ignored and has no side effect.
- **Overflow flag:** clr_ovf clears overflow. If clr_ovf and a drop occur in the same cycle, set wins.
- **Reset mid-operation:** all state returns to reset values; FIFO contents are discarded.

## Timing
- mic_clk period = 2·CLK_DIV clk cycles, duty cycle 50%.
- With en first sampled high in cycle 0:
  - mic_clk rises at cycle CLK_DIV.
  - PDM sample k is taken at cycle 2k·CLK_DIV.
- First push: empty deasserts, with dout valid, at cycle 2·DEC_RATE·CLK_DIV + 1. Later pushes follow every 2·DEC_RATE·CLK_DIV cycles.
- dout is first-word-fall-through:
  - It shows the next entry in the cycle after the rd pop.
  - A push into an empty FIFO is visible on dout in the cycle after the push.
- full and empty are registered and update in the cycle after the causing push or pop.
- Synchronizer latency is 2 cycles, which is less than CLK_DIV; a sampled bit therefore reflects data present ≥ CLK_DIV−2 cycles after the rising edge.

## Test plan
Bench parameters: CLK_DIV=4, DEC_RATE=8, FIFO_AW=2; one sample = 64 cycles; shift = 12.

1. **Reset and first sample.** Apply reset, then en=1 with mic_data=1 constant.
   - Reset outputs are as listed above.
   - mic_clk toggles every 4 cycles.
   - empty deasserts at cycle 65 with dout=0x7000 (saturated +8 → 7).
2. **Code values.**
   - mic_data=0 constant → dout=0x8000.
   - mic_data alternating 1/0 per mic_clk → dout=0x0000.
   - Six 1s in a window → v=4 → dout=0x4000.
3. **Overflow.** Run en=1 with no rd for 5 windows.
   - full=1 after 4 pushes.
   - 5th push dropped, overflow=1.
   - 4 pops return the first 4 samples in order, then empty=1.
   - clr_ovf → overflow=0.
4. **Simultaneous push and pop while full.** Hold rd=1 in the push cycle.
   - Both occur, overflow stays 0, full stays 1.
   - Next-oldest sample appears on dout.
5. **Disable and reset mid-window.**
   - en=0 at cycle 30 → mic_clk=0 and the partial window is discarded.
   - en=1 again → next sample is formed from a full, fresh 8-bit window.
   - reset with 2 entries queued → empty=1 and overflow=0 the next cycle.
6. **Empty pop and clear/set race.**
   - rd with empty=1 → no pointer change; the next push reads back correctly.
   - clr_ovf in the same cycle as a drop → overflow=1.
